inv_mix_columns_seq: RTL and testbench

//   Iterative AES InvMixColumns unit for the decrypt datapath; inverse of the MixColumns step.

---
 rtl/inv_mix_columns_seq_if.sv | 20 ++
 rtl/inv_mix_columns_seq.sv | 113 +++++++++++
 tb/tb_inv_mix_columns_seq.sv | 203 ++++++++++++++++++++
 3 files changed

// File: rtl/inv_mix_columns_seq_if.sv
// Handshake bundle for the iterative InvMixColumns unit: input state, output state and busy flag.
interface inv_mix_columns_seq_if;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] in_data;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] out_data;
    logic         busy;

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, busy
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, busy
    );
endinterface

// File: rtl/inv_mix_columns_seq.sv
// Iterative AES InvMixColumns: COLS_PER_CYCLE columns per clock, updated in place in one state register.
//
//   state   | meaning
//   IDLE    | in_ready=1, waiting for a state to accept
//   COMPUTE | transforming columns col_idx..col_idx+CPC-1 each clock
//   DONE    | out_valid=1, holding the result until out_ready
module inv_mix_columns_seq #(
    parameter int COLS_PER_CYCLE = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    inv_mix_columns_seq_if.slave  bus
);

    localparam logic [1:0] STEP     = 2'(COLS_PER_CYCLE);
    localparam logic [1:0] LAST_IDX = 2'(4 - COLS_PER_CYCLE);

    typedef enum logic [1:0] {IDLE, COMPUTE, DONE} state_t;

    state_t       state_q;
    logic [1:0]   col_idx_q;
    logic [127:0] data_q;
    logic [127:0] data_d;
    logic         out_valid_q;
    logic         in_ready_q;
    logic         busy_q;

    function automatic logic [7:0] xtime(input logic [7:0] x);
        return {x[6:0], 1'b0} ^ (x[7] ? 8'h1B : 8'h00);
    endfunction

    function automatic logic [31:0] inv_col(input logic [31:0] col);
        logic [7:0] a [4];
        logic [7:0] x2 [4];
        logic [7:0] x4 [4];
        logic [7:0] x8 [4];
        logic [7:0] m9 [4];
        logic [7:0] mb [4];
        logic [7:0] md [4];
        logic [7:0] me [4];
        for (int r = 0; r < 4; r++) begin
            a[r]  = col[31-8*r -: 8];
            x2[r] = xtime(a[r]);
            x4[r] = xtime(x2[r]);
            x8[r] = xtime(x4[r]);
            m9[r] = x8[r] ^ a[r];
            mb[r] = x8[r] ^ x2[r] ^ a[r];
            md[r] = x8[r] ^ x4[r] ^ a[r];
            me[r] = x8[r] ^ x4[r] ^ x2[r];
        end
        return {me[0] ^ mb[1] ^ md[2] ^ m9[3],
                m9[0] ^ me[1] ^ mb[2] ^ md[3],
                md[0] ^ m9[1] ^ me[2] ^ mb[3],
                mb[0] ^ md[1] ^ m9[2] ^ me[3]};
    endfunction

    // col_idx is always a multiple of CPC, so col_idx+j never passes column 3.
    always_comb begin
        int c;
        c      = 0;
        data_d = data_q;
        for (int j = 0; j < COLS_PER_CYCLE; j++) begin
            c = int'(col_idx_q) + j;
            data_d[127-32*c -: 32] = inv_col(data_q[127-32*c -: 32]);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            col_idx_q   <= 2'd0;
            data_q      <= '0;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            busy_q      <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.in_valid && in_ready_q) begin
                        data_q     <= bus.in_data;
                        col_idx_q  <= 2'd0;
                        in_ready_q <= 1'b0;
                        busy_q     <= 1'b1;
                        state_q    <= COMPUTE;
                    end
                end
                COMPUTE: begin
                    data_q    <= data_d;
                    col_idx_q <= col_idx_q + STEP;
                    if (col_idx_q == LAST_IDX) begin
                        out_valid_q <= 1'b1;
                        state_q     <= DONE;
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        busy_q      <= 1'b0;
                        state_q     <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = data_q;
    assign bus.busy      = busy_q;

endmodule

// File: tb/tb_inv_mix_columns_seq.sv
// Directed bench: three instances (CPC=1,2,4) run the vector table in lockstep; corner cases use CPC=1.
module tb_inv_mix_columns_seq;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    inv_mix_columns_seq_if bus0 ();
    inv_mix_columns_seq_if bus1 ();
    inv_mix_columns_seq_if bus2 ();

    inv_mix_columns_seq #(.COLS_PER_CYCLE(1)) u_dut_c1 (.clk(clk), .rst(rst), .bus(bus0));
    inv_mix_columns_seq #(.COLS_PER_CYCLE(2)) u_dut_c2 (.clk(clk), .rst(rst), .bus(bus1));
    inv_mix_columns_seq #(.COLS_PER_CYCLE(4)) u_dut_c4 (.clk(clk), .rst(rst), .bus(bus2));

    logic [2:0]   vld;
    logic [2:0]   rdy;
    logic [127:0] din;
    logic [2:0]   ov;
    logic [2:0]   ir;
    logic [2:0]   bsy;
    logic [127:0] dout [3];

    assign bus0.in_valid = vld[0];
    assign bus1.in_valid = vld[1];
    assign bus2.in_valid = vld[2];
    assign bus0.in_data  = din;
    assign bus1.in_data  = din;
    assign bus2.in_data  = din;
    assign bus0.out_ready = rdy[0];
    assign bus1.out_ready = rdy[1];
    assign bus2.out_ready = rdy[2];
    assign ov  = {bus2.out_valid, bus1.out_valid, bus0.out_valid};
    assign ir  = {bus2.in_ready,  bus1.in_ready,  bus0.in_ready};
    assign bsy = {bus2.busy,      bus1.busy,      bus0.busy};
    assign dout[0] = bus0.out_data;
    assign dout[1] = bus1.out_data;
    assign dout[2] = bus2.out_data;

    typedef struct {
        logic [127:0] din;
        logic [127:0] dout;
    } vec_t;
    vec_t vecs [5];

    int n_tests = 0;
    int n_fail  = 0;
    int excl_err = 0;

    always @(negedge clk) begin
        if (!rst && ((ov & ir) != 3'b000)) excl_err++;
    end

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [2:0] e;
        int bp_bad;
        int acc, outs, last, cyc;
        logic accepted;

        rst = 1'b1;
        vld = '0;
        rdy = '0;
        din = '0;

        vecs[0] = '{128'h8e4da1bc_9fdc589d_01010101_c6c6c6c6, 128'hdb135345_f20a225c_01010101_c6c6c6c6};
        vecs[1] = '{128'h4d7ebdf8_d5d5d7d6_00000000_ffffffff, 128'h2d26314c_d4d4d4d5_00000000_ffffffff};
        vecs[2] = '{128'hc6c6c6c6_01010101_9fdc589d_8e4da1bc, 128'hc6c6c6c6_01010101_f20a225c_db135345};
        vecs[3] = '{128'hd5d5d7d6_4d7ebdf8_ffffffff_046681e5, 128'hd4d4d4d5_2d26314c_ffffffff_d4bf5d30};
        vecs[4] = '{128'h0, 128'h0};

        #2;
        check("reset_out_valid", 128'(ov), 128'(3'b000));
        check("reset_in_ready",  128'(ir), 128'(3'b111));
        check("reset_busy",      128'(bsy), 128'(3'b000));
        for (int d = 0; d < 3; d++) check($sformatf("reset_out_data%0d", d), dout[d], 128'h0);

        @(negedge clk);
        rst = 1'b0;
        tick();

        // Lockstep table: latency per instance is 4, 2, 1 clocks.
        for (int i = 0; i < 5; i++) begin
            din = vecs[i].din;
            vld = 3'b111;
            check($sformatf("v%0d_in_ready", i), 128'(ir), 128'(3'b111));
            tick();
            vld = 3'b000;
            din = {$urandom, $urandom, $urandom, $urandom};
            for (int t = 1; t <= 4; t++) begin
                tick();
                e = {(t >= 1), (t >= 2), (t >= 4)};
                check($sformatf("v%0d_latency_t%0d", i, t), 128'(ov), 128'(e));
            end
            for (int d = 0; d < 3; d++)
                check($sformatf("v%0d_data_dut%0d", i, d), dout[d], vecs[i].dout);
            check($sformatf("v%0d_busy_done", i), 128'(bsy), 128'(3'b111));
            check($sformatf("v%0d_in_ready_done", i), 128'(ir), 128'(3'b000));
            rdy = 3'b111;
            tick();
            rdy = 3'b000;
            check($sformatf("v%0d_out_valid_idle", i), 128'(ov), 128'(3'b000));
            check($sformatf("v%0d_in_ready_idle", i), 128'(ir), 128'(3'b111));
            check($sformatf("v%0d_busy_idle", i), 128'(bsy), 128'(3'b000));
        end

        // Backpressure on CPC=1: hold DONE for 10 cycles while in_valid pulses.
        din = vecs[0].din;
        vld = 3'b001;
        tick();
        vld = 3'b000;
        repeat (4) tick();
        check("bp_out_valid_entry", 128'(ov[0]), 128'(1'b1));
        bp_bad = 0;
        for (int c = 0; c < 10; c++) begin
            vld[0] = c[0];
            din = {$urandom, $urandom, $urandom, $urandom};
            tick();
            if (ov[0] !== 1'b1 || ir[0] !== 1'b0 || bsy[0] !== 1'b1 || dout[0] !== vecs[0].dout)
                bp_bad++;
        end
        vld = 3'b000;
        check("bp_stable_cycles_bad", 128'(bp_bad), 128'(0));
        rdy = 3'b001;
        tick();
        rdy = 3'b000;
        check("bp_release_out_valid", 128'(ov[0]), 128'(1'b0));
        check("bp_release_in_ready", 128'(ir[0]), 128'(1'b1));

        // Reset abort two cycles after accept.
        din = vecs[1].din;
        vld = 3'b001;
        tick();
        vld = 3'b000;
        tick();
        tick();
        rst = 1'b1;
        #1;
        check("abort_out_valid", 128'(ov[0]), 128'(1'b0));
        check("abort_busy", 128'(bsy[0]), 128'(1'b0));
        check("abort_in_ready", 128'(ir[0]), 128'(1'b1));
        check("abort_out_data", dout[0], 128'h0);
        rst = 1'b0;
        din = vecs[2].din;
        vld = 3'b001;
        tick();
        vld = 3'b000;
        repeat (4) tick();
        check("post_abort_out_valid", 128'(ov[0]), 128'(1'b1));
        check("post_abort_data", dout[0], vecs[2].dout);
        rdy = 3'b001;
        tick();
        rdy = 3'b000;

        // Back-to-back on CPC=1: results every N+2 = 6 cycles, in order.
        rdy = 3'b001;
        vld = 3'b001;
        din = vecs[0].din;
        acc = 0; outs = 0; last = 0; cyc = 0;
        while (outs < 3 && cyc < 60) begin
            accepted = vld[0] && ir[0];
            tick();
            cyc++;
            if (accepted) begin
                acc++;
                if (acc < 3) din = vecs[acc].din;
                else begin
                    vld = 3'b000;
                    din = '0;
                end
            end
            if (ov[0]) begin
                check($sformatf("b2b_data%0d", outs), dout[0], vecs[outs].dout);
                if (outs > 0) check($sformatf("b2b_spacing%0d", outs), 128'(cyc - last), 128'(6));
                last = cyc;
                outs++;
            end
        end
        vld = 3'b000;
        rdy = 3'b000;
        check("b2b_result_count", 128'(outs), 128'(3));
        check("b2b_accept_count", 128'(acc), 128'(3));

        tick();
        check("valid_ready_exclusive_violations", 128'(excl_err), 128'(0));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
